mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator-side controller for the single-port-write/single-port-read registered memory (2-cycle read latency).
//  Accepts independent valid/ready write and read request channels from AXI-MM-style logic.
//  Drives the memory's waddr/wen/wdata/raddr and tags reads with an ID through the latency pipeline.
//  Returns write acks and read data through backpressurable response channels, buffered in a credit-checked FIFO.
// PARAMETERS
//  DATAW       8    data width; matches the memory's DATAW
//  DEPTH       512  memory depth in words
//  ADDRW       $clog2(DEPTH)  address width
//  IDW         4    read-request ID width
//  RSP_DEPTH   4    read-response FIFO entries; legal >=2, >=4 sustains 1 read/cycle
//  WR_ACK_MAX  4    maximum outstanding unacknowledged writes; legal >=1
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  wr_valid       in   1      write request valid
//  wr_ready       out  1      write request accepted when wr_valid && wr_ready
//  wr_addr        in   ADDRW  write address
//  wr_data        in   DATAW  write data
//  wr_resp_valid  out  1      write ack pending
//  wr_resp_ready  in   1      write ack consumed
//  rd_valid       in   1      read request valid
//  rd_ready       out  1      read request accepted when rd_valid && rd_ready
//  rd_addr        in   ADDRW  read address
//  rd_id          in   IDW    read tag, returned with data
//  rd_resp_valid  out  1      read data valid
//  rd_resp_ready  in   1      read data consumed
//  rd_resp_data   out  DATAW  read data
//  rd_resp_id     out  IDW    tag of the returned read
//  mem_waddr      out  ADDRW  to memory waddr (= wr_addr)
//  mem_wen        out  1      to memory wen (= write accept)
//  mem_wdata      out  DATAW  to memory wdata (= wr_data)
//  mem_raddr      out  ADDRW  to memory raddr (= rd_addr)
//  mem_rdata      in   DATAW  from memory rdata
// BEHAVIOUR
//  Reset: pipeline valids, FIFO, ack counter cleared. During rst wr_ready=rd_ready=mem_wen=0; rd_resp_valid=wr_resp_valid=0; data/id outputs 0.
//  mem_wen = wr_valid && wr_ready (combinational); mem_waddr/mem_wdata/mem_raddr are combinational pass-throughs.
//  Read pipeline: 2-stage {valid,id} shift register. Accept at cycle t -> mem_rdata sampled into FIFO at end of t+2.
//    rd_resp_valid asserted in t+3 at the earliest: 3-cycle accept->response latency.
//  Credit: inflight (0..2) + fifo_count < RSP_DEPTH -> rd_ready. Uses registered values only; a same-cycle pop grants no credit.
//    No read is ever accepted without a guaranteed FIFO slot; data is never dropped.
//  FIFO: in-order wrap-around pointers. rd_resp_valid = (count!=0); head data/id stay stable until rd_resp_ready.
//    Simultaneous push and pop keep count unchanged. Full/empty never corrupt pointers.
//  Write acks: ack_cnt += accept, -= (wr_resp_valid && wr_resp_ready); simultaneous inc+dec leaves it unchanged.
//    wr_ready = ack_cnt < WR_ACK_MAX. wr_resp_valid = (ack_cnt != 0); first ack visible the cycle after accept.
//  Ordering: the memory forwards writes. A read accepted in the same cycle as, or any cycle after, a write accept to the same address returns the new data.
//  Write and read channels are independent; both may be accepted in the same cycle.
//  Reset mid-operation: in-flight reads and queued responses are discarded; no response is emitted after reset for pre-reset requests.
//  Requester-side valid must stay high with stable payload until ready; the controller holds its response valids under the same rule.
// TESTING
//  1 Hold rst 3 cycles -> all outputs 0; the cycle after deassertion wr_ready=rd_ready=1.
//  2 Write addr 5 = 0xA5, then read addr 5 id 3 -> wr_resp_valid the cycle after the write; rd_resp 0xA5/id 3 exactly 3 cycles after the read accept.
//  3 Same-cycle write addr 7 = 0x3C and read addr 7 id 1 -> rd_resp_data 0x3C.
//  4 Write addr 0..7 = 0x10+i, then 8 back-to-back reads with rd_resp_ready=1 -> rd_ready stays 1; 8 consecutive responses 0x10..0x17 in order.
//  5 rd_resp_ready=0, read requests held valid -> exactly 4 accepted, then rd_ready=0; raise ready -> 4 in-order responses, then rd_ready=1.
//  6 wr_resp_ready=0 plus 5 writes -> wr_ready=0 after 4 accepts; pulse ready -> one ack consumed, 5th accepted. Reset during an in-flight read -> no rd_resp_valid afterward.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel bundle between an AXI-MM-style requester (master)
// and mem_access_ctrl (slave).
interface mem_access_ctrl_if #(
  parameter int DATAW = 8,
  parameter int ADDRW = 9,
  parameter int IDW   = 4
);
  logic             wr_valid;
  logic             wr_ready;
  logic [ADDRW-1:0] wr_addr;
  logic [DATAW-1:0] wr_data;
  logic             wr_resp_valid;
  logic             wr_resp_ready;

  logic             rd_valid;
  logic             rd_ready;
  logic [ADDRW-1:0] rd_addr;
  logic [IDW-1:0]   rd_id;
  logic             rd_resp_valid;
  logic             rd_resp_ready;
  logic [DATAW-1:0] rd_resp_data;
  logic [IDW-1:0]   rd_resp_id;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_resp_ready,
    output rd_valid, rd_addr, rd_id, rd_resp_ready,
    input  wr_ready, wr_resp_valid,
    input  rd_ready, rd_resp_valid, rd_resp_data, rd_resp_id
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_resp_ready,
    input  rd_valid, rd_addr, rd_id, rd_resp_ready,
    output wr_ready, wr_resp_valid,
    output rd_ready, rd_resp_valid, rd_resp_data, rd_resp_id
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a registered memory with 2-cycle read latency:
// tags reads through the latency pipe, buffers responses, and counts write acks.
module mem_access_ctrl #(
  parameter int DATAW      = 8,
  parameter int DEPTH      = 512,
  parameter int ADDRW      = $clog2(DEPTH),
  parameter int IDW        = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int WR_ACK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus,
  output logic [ADDRW-1:0] o_mem_waddr,
  output logic             o_mem_wen,
  output logic [DATAW-1:0] o_mem_wdata,
  output logic [ADDRW-1:0] o_mem_raddr,
  input  logic [DATAW-1:0] i_mem_rdata
);
  localparam int PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNTW = $clog2(RSP_DEPTH + 1);
  localparam int SUMW = CNTW + 1;
  localparam int ACKW = $clog2(WR_ACK_MAX + 1);

  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(RSP_DEPTH - 1);
  localparam logic [SUMW-1:0] RSP_LIM  = SUMW'(RSP_DEPTH);
  localparam logic [ACKW-1:0] ACK_LIM  = ACKW'(WR_ACK_MAX);

  logic             w_wrAccept;
  logic             w_rdAccept;
  logic             w_wrAck;
  logic             w_push;
  logic             w_pop;
  logic             w_rspValid;
  logic [SUMW-1:0]  w_credUsed;

  logic             r_v1;
  logic             r_v2;
  logic [IDW-1:0]   r_id1;
  logic [IDW-1:0]   r_id2;

  logic [DATAW-1:0] r_fifoData [RSP_DEPTH];
  logic [IDW-1:0]   r_fifoId   [RSP_DEPTH];
  logic [PTRW-1:0]  r_wrPtr;
  logic [PTRW-1:0]  r_rdPtr;
  logic [CNTW-1:0]  r_count;

  logic [ACKW-1:0]  r_ackCnt;

  // Credit counts reads still in the latency pipe plus queued responses, so
  // every accepted read already owns a FIFO slot when its data arrives.
  assign w_credUsed = SUMW'(r_v1) + SUMW'(r_v2) + SUMW'(r_count);

  assign bus.wr_ready = !rst && (r_ackCnt < ACK_LIM);
  assign bus.rd_ready = !rst && (w_credUsed < RSP_LIM);

  assign w_wrAccept = bus.wr_valid && bus.wr_ready;
  assign w_rdAccept = bus.rd_valid && bus.rd_ready;

  assign o_mem_wen   = w_wrAccept;
  assign o_mem_waddr = rst ? '0 : bus.wr_addr;
  assign o_mem_wdata = rst ? '0 : bus.wr_data;
  assign o_mem_raddr = rst ? '0 : bus.rd_addr;

  assign bus.wr_resp_valid = !rst && (r_ackCnt != '0);
  assign w_wrAck           = bus.wr_resp_valid && bus.wr_resp_ready;

  assign w_rspValid        = !rst && (r_count != '0);
  assign bus.rd_resp_valid = w_rspValid;
  assign bus.rd_resp_data  = w_rspValid ? r_fifoData[r_rdPtr] : '0;
  assign bus.rd_resp_id    = w_rspValid ? r_fifoId[r_rdPtr]   : '0;

  assign w_push = r_v2;
  assign w_pop  = w_rspValid && bus.rd_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
    end else begin
      r_v1  <= w_rdAccept;
      r_id1 <= bus.rd_id;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= i_mem_rdata;
      r_fifoId[r_wrPtr]   <= r_id2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTRW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTRW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNTW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ackCnt <= '0;
    end else if (w_wrAccept && !w_wrAck) begin
      r_ackCnt <= r_ackCnt + ACKW'(1);
    end else if (!w_wrAccept && w_wrAck) begin
      r_ackCnt <= r_ackCnt - ACKW'(1);
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus a randomized run against
// a transaction-level model of the request/response rules.
module tb_mem_access_ctrl;
  localparam int DATAW      = 8;
  localparam int DEPTH      = 512;
  localparam int ADDRW      = 9;
  localparam int IDW        = 4;
  localparam int RSP_DEPTH  = 4;
  localparam int WR_ACK_MAX = 4;

  typedef struct {
    logic [DATAW-1:0] data;
    logic [IDW-1:0]   id;
    int               acc;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ADDRW-1:0] memWaddr;
  logic             memWen;
  logic [DATAW-1:0] memWdata;
  logic [ADDRW-1:0] memRaddr;
  logic [DATAW-1:0] memRdata;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl_if #(.DATAW(DATAW), .ADDRW(ADDRW), .IDW(IDW)) bus ();

  mem_access_ctrl #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .IDW(IDW),
    .RSP_DEPTH(RSP_DEPTH), .WR_ACK_MAX(WR_ACK_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_mem_waddr(memWaddr), .o_mem_wen(memWen), .o_mem_wdata(memWdata),
    .o_mem_raddr(memRaddr), .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  // Registered memory, 2-cycle read latency, same-cycle write forwarding.
  logic [DATAW-1:0] memArr [DEPTH];
  logic [DATAW-1:0] memS1;
  always @(posedge clk) begin
    memS1    <= (memWen && memWaddr == memRaddr) ? memWdata : memArr[memRaddr];
    memRdata <= memS1;
    if (memWen) memArr[memWaddr] <= memWdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_id = '0;
    bus.wr_resp_ready = 1'b1; bus.rd_resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_ready, bus.rd_ready, memWen, bus.wr_resp_valid, bus.rd_resp_valid} !== 5'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl cycle %0d: got %b, expected 00000", i,
                 {bus.wr_ready, bus.rd_ready, memWen, bus.wr_resp_valid, bus.rd_resp_valid});
      end
      checks++;
      if ({bus.rd_resp_data, bus.rd_resp_id, memWaddr, memWdata, memRaddr} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_data cycle %0d: got %h, expected 0", i,
                 {bus.rd_resp_data, bus.rd_resp_id, memWaddr, memWdata, memRaddr});
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 11", {bus.wr_ready, bus.rd_ready});
    end
    tick();
  endtask

  task automatic test_write_read();
    int lat = -1;
    logic [DATAW-1:0] d;
    logic [IDW-1:0] id;
    idle_inputs();
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd5; bus.wr_data = 8'hA5;
    @(negedge clk);
    checks++;
    if ({bus.wr_ready, memWen} !== 2'b11) begin
      errors++; $display("[TB] FAIL wr_accept: got %b, expected 11", {bus.wr_ready, memWen});
    end
    checks++;
    if (memWaddr !== 9'd5 || memWdata !== 8'hA5) begin
      errors++; $display("[TB] FAIL mem_wr_bus: got %0h/%0h, expected 5/a5", memWaddr, memWdata);
    end
    checks++;
    if (bus.wr_resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_ack_early: got %b, expected 0", bus.wr_resp_valid);
    end
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_ack: got %b, expected 1", bus.wr_resp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_ack_consumed: got %b, expected 0", bus.wr_resp_valid);
    end
    tick();
    bus.rd_valid = 1'b1; bus.rd_addr = 9'd5; bus.rd_id = 4'd3;
    @(negedge clk);
    checks++;
    if (bus.rd_ready !== 1'b1 || memRaddr !== 9'd5) begin
      errors++; $display("[TB] FAIL rd_accept: got %b/%0h, expected 1/5", bus.rd_ready, memRaddr);
    end
    tick();
    bus.rd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rd_resp_valid === 1'b1 && lat < 0) begin
        lat = k; d = bus.rd_resp_data; id = bus.rd_resp_id;
      end
      tick();
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("[TB] FAIL rd_latency: got %0d, expected 3", lat);
    end
    checks++;
    if (d !== 8'hA5 || id !== 4'd3) begin
      errors++; $display("[TB] FAIL rd_data: got %h/%h, expected a5/3", d, id);
    end
  endtask

  task automatic test_same_cycle();
    int lat = -1;
    logic [DATAW-1:0] d;
    logic [IDW-1:0] id;
    idle_inputs();
    bus.wr_valid = 1'b1; bus.wr_addr = 9'd7; bus.wr_data = 8'h3C;
    bus.rd_valid = 1'b1; bus.rd_addr = 9'd7; bus.rd_id = 4'd1;
    @(negedge clk);
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b11) begin
      errors++; $display("[TB] FAIL same_cycle_accept: got %b, expected 11", {bus.wr_ready, bus.rd_ready});
    end
    tick();
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rd_resp_valid === 1'b1 && lat < 0) begin
        lat = k; d = bus.rd_resp_data; id = bus.rd_resp_id;
      end
      tick();
    end
    checks++;
    if (lat != 3 || d !== 8'h3C || id !== 4'd1) begin
      errors++; $display("[TB] FAIL forward_data: got lat %0d %h/%h, expected lat 3 3c/1", lat, d, id);
    end
  endtask

  task automatic test_back_to_back();
    int wrAcc = 0, notReady = 0, n = 0;
    logic [DATAW-1:0] rd [16];
    logic [IDW-1:0] ri [16];
    int rc [16];
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = ADDRW'(i); bus.wr_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (bus.wr_ready === 1'b1) wrAcc++;
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    checks++;
    if (wrAcc != 8) begin
      errors++; $display("[TB] FAIL b2b_writes: got %0d accepts, expected 8", wrAcc);
    end
    for (int c = 0; c < 16; c++) begin
      bus.rd_valid = (c < 8);
      bus.rd_addr  = ADDRW'(c % 8);
      bus.rd_id    = IDW'(c);
      @(negedge clk);
      if (c < 8 && bus.rd_ready !== 1'b1) notReady++;
      if (bus.rd_resp_valid === 1'b1 && n < 16) begin
        rd[n] = bus.rd_resp_data; ri[n] = bus.rd_resp_id; rc[n] = c; n++;
      end
      tick();
    end
    bus.rd_valid = 1'b0;
    checks++;
    if (notReady != 0) begin
      errors++; $display("[TB] FAIL b2b_rd_ready: got %0d stalls, expected 0", notReady);
    end
    checks++;
    if (n != 8) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d responses, expected 8", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rd[i] !== 8'h10 + 8'(i) || ri[i] !== IDW'(i)) begin
          errors++; $display("[TB] FAIL b2b_rsp%0d: got %h/%h, expected %h/%h", i, rd[i], ri[i], 8'h10 + 8'(i), i);
        end
      end
      checks++;
      if (rc[0] != 3 || rc[7] != 10) begin
        errors++; $display("[TB] FAIL b2b_timing: got first %0d last %0d, expected 3 and 10", rc[0], rc[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, n = 0, k = 0;
    logic [DATAW-1:0] rd [8];
    logic [IDW-1:0] ri [8];
    idle_inputs();
    bus.rd_resp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = ADDRW'(k); bus.rd_id = IDW'(k);
      @(negedge clk);
      if (bus.rd_ready === 1'b1) begin acc++; k++; end
      tick();
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || bus.rd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_credit: got %0d accepts ready %b, expected 4 and 0", acc, bus.rd_ready);
    end
    checks++;
    if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== 8'h10 || bus.rd_resp_id !== 4'd0) begin
      errors++; $display("[TB] FAIL bp_head_hold: got %b %h/%h, expected 1 10/0",
                         bus.rd_resp_valid, bus.rd_resp_data, bus.rd_resp_id);
    end
    tick();
    bus.rd_resp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      bus.rd_valid = (k < 5); bus.rd_addr = ADDRW'(k); bus.rd_id = IDW'(k);
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready === 1'b1) begin acc++; k++; end
      if (bus.rd_resp_valid === 1'b1 && n < 8) begin
        rd[n] = bus.rd_resp_data; ri[n] = bus.rd_resp_id; n++;
      end
      tick();
    end
    bus.rd_valid = 1'b0;
    checks++;
    if (acc != 5 || n != 5) begin
      errors++; $display("[TB] FAIL bp_drain: got %0d accepts %0d responses, expected 5 and 5", acc, n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rd[i] !== 8'h10 + 8'(i) || ri[i] !== IDW'(i)) begin
          errors++; $display("[TB] FAIL bp_rsp%0d: got %h/%h, expected %h/%h", i, rd[i], ri[i], 8'h10 + 8'(i), i);
        end
      end
    end
  endtask

  task automatic test_write_ack();
    int acc = 0, k = 0, acks = 0;
    idle_inputs();
    bus.wr_resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = ADDRW'(20 + k); bus.wr_data = 8'($urandom);
      @(negedge clk);
      if (bus.wr_ready === 1'b1) begin acc++; k++; end
      tick();
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || bus.wr_ready !== 1'b0 || bus.wr_resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL ack_limit: got %0d accepts ready %b ack %b, expected 4 0 1",
                         acc, bus.wr_ready, bus.wr_resp_valid);
    end
    tick();
    bus.wr_resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.wr_resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL ack_pulse: got ready %b ack %b, expected 0 1", bus.wr_ready, bus.wr_resp_valid);
    end
    tick();
    bus.wr_resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_ready !== 1'b1 || memWen !== 1'b1) begin
      errors++; $display("[TB] FAIL ack_fifth: got ready %b wen %b, expected 1 1", bus.wr_ready, memWen);
    end
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL ack_refull: got %b, expected 0", bus.wr_ready);
    end
    tick();
    bus.wr_resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.wr_resp_valid === 1'b1) acks++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (acks != 4 || bus.wr_resp_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ack_drain: got %0d acks valid %b ready %b, expected 4 0 1",
                         acks, bus.wr_resp_valid, bus.wr_ready);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int acc = 0, late = 0;
    idle_inputs();
    bus.rd_resp_ready = 1'b0;
    bus.wr_resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = ADDRW'(c); bus.rd_id = IDW'(c);
      bus.wr_valid = (c == 0); bus.wr_addr = 9'd40; bus.wr_data = 8'h77;
      @(negedge clk);
      if (bus.rd_ready === 1'b1) acc++;
      tick();
    end
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc != 3 || bus.rd_resp_valid !== 1'b1 || bus.wr_resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_queue: got %0d accepts rsp %b ack %b, expected 3 1 1",
                         acc, bus.rd_resp_valid, bus.wr_resp_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rd_resp_ready = 1'b1;
    bus.wr_resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rd_resp_valid !== 1'b0 || bus.wr_resp_valid !== 1'b0) late++;
      tick();
    end
    checks++;
    if (late != 0) begin
      errors++; $display("[TB] FAIL post_reset_rsp: got %0d cycles with responses, expected 0", late);
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    rd_t expQ[$];
    rd_t e;
    logic [DATAW-1:0] refMem [16];
    int ackOut = 0;
    logic active, wrPend = 0, rdPend = 0;
    logic expWrReady, expAckValid, expRdReady, expRspValid;
    logic [3:0] wA, rA;
    logic [DATAW-1:0] wD;
    logic [IDW-1:0] rI;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      refMem[i] = 8'($urandom);
      bus.wr_valid = 1'b1; bus.wr_addr = ADDRW'(32 + i); bus.wr_data = refMem[i];
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    for (int c = 0; c < N + 16; c++) begin
      active = (c < N);
      if (!wrPend && active && $urandom_range(0, 1) == 1) begin
        wrPend = 1'b1; wA = 4'($urandom); wD = 8'($urandom);
      end
      if (!rdPend && active && $urandom_range(0, 2) != 0) begin
        rdPend = 1'b1; rA = 4'($urandom); rI = IDW'($urandom);
      end
      bus.wr_valid = wrPend; bus.wr_addr = ADDRW'(32) + ADDRW'(wA); bus.wr_data = wD;
      bus.rd_valid = rdPend; bus.rd_addr = ADDRW'(32) + ADDRW'(rA); bus.rd_id = rI;
      bus.wr_resp_ready = active ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rd_resp_ready = active ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      expWrReady  = (ackOut < WR_ACK_MAX);
      expAckValid = (ackOut != 0);
      expRdReady  = (expQ.size() < RSP_DEPTH);
      expRspValid = (expQ.size() != 0) && (expQ[0].acc + 3 <= c);
      checks++;
      if (bus.wr_ready !== expWrReady || bus.wr_resp_valid !== expAckValid) begin
        errors++; $display("[TB] FAIL rnd_wr c%0d: got ready %b ack %b, expected %b %b",
                           c, bus.wr_ready, bus.wr_resp_valid, expWrReady, expAckValid);
      end
      checks++;
      if (bus.rd_ready !== expRdReady || bus.rd_resp_valid !== expRspValid) begin
        errors++; $display("[TB] FAIL rnd_rd c%0d: got ready %b rsp %b, expected %b %b",
                           c, bus.rd_ready, bus.rd_resp_valid, expRdReady, expRspValid);
      end
      if (expRspValid) begin
        checks++;
        if (bus.rd_resp_data !== expQ[0].data || bus.rd_resp_id !== expQ[0].id) begin
          errors++; $display("[TB] FAIL rnd_rsp c%0d: got %h/%h, expected %h/%h",
                             c, bus.rd_resp_data, bus.rd_resp_id, expQ[0].data, expQ[0].id);
        end
        if (bus.rd_resp_ready) void'(expQ.pop_front());
      end
      if (rdPend && expRdReady) begin
        e.data = (wrPend && expWrReady && wA == rA) ? wD : refMem[rA];
        e.id   = rI;
        e.acc  = c;
        expQ.push_back(e);
        rdPend = 1'b0;
      end
      if (wrPend && expWrReady) begin
        refMem[wA] = wD;
        ackOut++;
        wrPend = 1'b0;
      end
      if (expAckValid && bus.wr_resp_ready) ackOut--;
      tick();
    end
    idle_inputs();
    checks++;
    if (expQ.size() != 0 || ackOut != 0 || wrPend || rdPend) begin
      errors++; $display("[TB] FAIL rnd_drain: got %0d reads %0d acks pending, expected 0 0",
                         expQ.size(), ackOut);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_same_cycle();
    test_back_to_back();
    test_backpressure();
    test_write_ack();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
